// File: rtl/spi_pkg.sv
// Shared state encoding, SPI mode constants and sizing helper for the SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    // {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int cs_sel_width(input int num_cs);
        return (num_cs <= 1) ? 1 : $clog2(num_cs);
    endfunction

endpackage

// File: rtl/spi_half_period_tick.sv
// Free-running half-period divider: one-cycle tick every HALF_PERIOD clocks while enabled.
module spi_half_period_tick #(
    parameter int HALF_PERIOD = 125
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [15:0] LAST = 16'(HALF_PERIOD - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_gen.sv
// Full-duplex SPI master: run-time CPOL/CPHA, selectable bit order, NUM_CS chip selects,
// valid/ready transmit handshake and a one-cycle rx_valid pulse per received word.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter  int DATA_WIDTH          = 8,
    parameter  int CLOCK_DIVIDER_COUNT = 125,
    parameter  int NUM_CS              = 1,
    localparam int CS_SEL_W            = cs_sel_width(NUM_CS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [CS_SEL_W-1:0]   cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic [NUM_CS-1:0]     cs_n,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int               EDGE_W    = $clog2(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
        return r;
    endfunction

    spi_state_e            state_q, state_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  busy_q, busy_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [EDGE_W-1:0]     edge_q, edge_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;

    logic                  accept;
    logic                  tick;
    logic                  lead_edge;
    logic                  last_edge;
    logic [DATA_WIDTH-1:0] tx_word;

    assign accept    = tx_valid && tx_ready_q;
    assign lead_edge = ~edge_q[0];
    assign last_edge = (edge_q == LAST_EDGE);
    // Words are normalised to MSB-first so the shifters only ever move one way.
    assign tx_word   = lsb_first ? bit_rev(tx_data) : tx_data;

    spi_half_period_tick #(
        .HALF_PERIOD(CLOCK_DIVIDER_COUNT)
    ) u_tick (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (busy_q),
        .clr_i (accept),
        .tick_o(tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        cs_n_d     = cs_n_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        edge_d     = edge_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;

        case (state_q)
            IDLE: begin
                tx_ready_d = 1'b1;
                if (accept) begin
                    state_d    = LEAD;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    lsb_d      = lsb_first;
                    sck_d      = cpol;
                    edge_d     = '0;
                    cs_n_d     = '1;
                    for (int i = 0; i < NUM_CS; i++) begin
                        if (cs_sel == CS_SEL_W'(i)) cs_n_d[i] = 1'b0;
                    end
                    if (cpha) begin
                        mosi_d  = 1'b0;
                        tx_sr_d = tx_word;
                    end else begin
                        mosi_d  = tx_word[DATA_WIDTH-1];
                        tx_sr_d = tx_word << 1;
                    end
                end
            end
            LEAD: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (tick) begin
                    sck_d  = ~sck_q;
                    edge_d = edge_q + EDGE_W'(1);
                    // cpha=0 samples on leading edges, cpha=1 on trailing edges.
                    if (lead_edge != cpha_q) rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], miso};
                    if (cpha_q ? lead_edge : (!lead_edge && !last_edge)) begin
                        mosi_d  = tx_sr_q[DATA_WIDTH-1];
                        tx_sr_d = tx_sr_q << 1;
                    end
                    if (last_edge) state_d = TRAIL;
                end
            end
            TRAIL: begin
                if (tick) begin
                    state_d    = IDLE;
                    cs_n_d     = '1;
                    sck_d      = cpol_q;
                    mosi_d     = 1'b0;
                    busy_d     = 1'b0;
                    tx_ready_d = 1'b1;
                    rx_valid_d = 1'b1;
                    rx_data_d  = lsb_q ? bit_rev(rx_sr_q) : rx_sr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            cs_n_q     <= '1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            edge_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            cs_n_q     <= cs_n_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            edge_q     <= edge_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign cs_n     = cs_n_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: two instances (H=4/4 CS and H=1/3 CS) driven through a shared
// SPI slave model that checks timing, bit order, chip selects and received data.
module tb_spi_master_gen;
    import spi_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, tx_valid, cpol, cpha, lsb_first, miso, sel;
    logic [W-1:0] tx_data;
    logic [1:0]   cs_sel;

    logic         tx_valid_a, tx_ready_a, rx_valid_a, busy_a, sck_a, mosi_a;
    logic         tx_valid_b, tx_ready_b, rx_valid_b, busy_b, sck_b, mosi_b;
    logic [W-1:0] rx_data_a, rx_data_b;
    logic [3:0]   cs_n_a;
    logic [2:0]   cs_n_b;

    logic         tx_ready_m, rx_valid_m, busy_m, sck_m, mosi_m;
    logic [W-1:0] rx_data_m;
    logic [3:0]   cs_n_m;

    assign tx_valid_a = tx_valid & ~sel;
    assign tx_valid_b = tx_valid & sel;
    assign tx_ready_m = sel ? tx_ready_b : tx_ready_a;
    assign rx_valid_m = sel ? rx_valid_b : rx_valid_a;
    assign busy_m     = sel ? busy_b : busy_a;
    assign sck_m      = sel ? sck_b : sck_a;
    assign mosi_m     = sel ? mosi_b : mosi_a;
    assign rx_data_m  = sel ? rx_data_b : rx_data_a;
    assign cs_n_m     = sel ? {1'b1, cs_n_b} : cs_n_a;

    spi_master_gen #(.DATA_WIDTH(W), .CLOCK_DIVIDER_COUNT(4), .NUM_CS(4)) dut_a (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .busy(busy_a), .cs_n(cs_n_a), .sck(sck_a), .mosi(mosi_a), .miso(miso)
    );

    spi_master_gen #(.DATA_WIDTH(W), .CLOCK_DIVIDER_COUNT(1), .NUM_CS(3)) dut_b (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .busy(busy_b), .cs_n(cs_n_b), .sck(sck_b), .mosi(mosi_b), .miso(miso)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_cs(input logic [1:0] cs);
        int ncs = sel ? 3 : 4;
        return (int'(cs) < ncs) ? ~(4'b0001 << cs) : 4'hF;
    endfunction

    // i-th bit on the wire for a word in the given order
    function automatic logic bit_at(input logic [W-1:0] v, input bit lsb, input int i);
        return lsb ? v[i] : v[W-1-i];
    endfunction

    task automatic transfer(input logic [W-1:0] w, input logic [W-1:0] sw, input logic [1:0] mode,
                            input bit lsb, input logic [1:0] cs, input bit loop, input bit scramble,
                            input bit pre, input bit b2b, input logic [W-1:0] w2);
        int         h     = sel ? 1 : 4;
        int         total = (2 * W + 2) * h;
        logic       pol   = mode[1];
        logic       pha   = mode[0];
        logic [3:0] ecs   = exp_cs(cs);
        int t = 0, edges = 0, first_t = -1, last_t = -1, t_end = -1;
        int gap_err = 0, stab_err = 0, pat_err = 0, rdy_err = 0, busy_cnt = 0, mi = 0, mo = 0;
        logic [W-1:0] got_mosi = '0;
        logic [W-1:0] exp_rx;
        logic sck_p, mosi_p;
        bit   lead;

        exp_rx = loop ? w : sw;
        if (!pre) begin
            for (int i = 0; i < 50 && tx_ready_m !== 1'b1; i++) @(negedge clk);
            check_eq("ready_before", tx_ready_m, 1);
            tx_data = w; cs_sel = cs; cpol = pol; cpha = pha; lsb_first = lsb; tx_valid = 1'b1;
        end
        @(negedge clk);
        check_eq("accept", {busy_m, tx_ready_m, sck_m}, {1'b1, 1'b0, pol});
        if (pre) check_eq("b2b_cs_relow", cs_n_m, ecs);
        if (!scramble) tx_valid = 1'b0;
        sck_p  = sck_m;
        mosi_p = mosi_m;
        miso   = loop ? mosi_m : (pha ? 1'b0 : bit_at(sw, lsb, 0));
        mi     = pha ? 0 : 1;
        while (t <= total + 4) begin
            if (rx_valid_m === 1'b1) begin
                t_end = t;
                break;
            end
            if (busy_m === 1'b1) busy_cnt++;
            if (cs_n_m !== ecs) pat_err++;
            if (tx_ready_m !== 1'b0) rdy_err++;
            if (sck_m !== sck_p) begin
                edges++;
                if (first_t < 0) first_t = t;
                else if (t - last_t != h) gap_err++;
                last_t = t;
                lead = (edges % 2) == 1;
                if (lead != pha) begin
                    if (mosi_m !== mosi_p) stab_err++;
                    if (mo < W) begin
                        if (lsb) got_mosi[mo] = mosi_p;
                        else     got_mosi[W-1-mo] = mosi_p;
                    end
                    mo++;
                end else if (!loop && mi < W) begin
                    miso = bit_at(sw, lsb, mi);
                    mi++;
                end
            end
            if (loop) miso = mosi_m;
            if (scramble) tx_data = W'($urandom);
            sck_p  = sck_m;
            mosi_p = mosi_m;
            @(negedge clk);
            t++;
        end
        check_eq("rx_valid_time", t_end, total);
        if (t_end >= 0) begin
            check_eq("end_state", {busy_m, tx_ready_m, mosi_m, cs_n_m}, {1'b0, 1'b1, 1'b0, 4'hF});
            check_eq("rx_data", rx_data_m, exp_rx);
        end
        check_eq("busy_cycles", busy_cnt, total);
        check_eq("cs_pattern_errs", pat_err, 0);
        check_eq("ready_low_errs", rdy_err, 0);
        check_eq("sck_edges", edges, 2 * W);
        check_eq("first_edge_t", first_t, 2 * h);
        check_eq("half_period_errs", gap_err, 0);
        check_eq("trail_len", t_end - last_t, h);
        check_eq("mosi_word", got_mosi, w);
        check_eq("mosi_stable_errs", stab_err, 0);
        if (b2b) begin
            tx_data  = w2;
            tx_valid = 1'b1;
        end else begin
            tx_valid = 1'b0;
            @(negedge clk);
            check_eq("idle_after", {rx_valid_m, cs_n_m, sck_m, mosi_m, tx_ready_m, busy_m},
                     {1'b0, 4'hF, pol, 1'b0, 1'b1, 1'b0});
            check_eq("rx_hold", rx_data_m, exp_rx);
        end
    endtask

    task automatic reset_mid();
        int   edges = 0;
        int   rxv   = 0;
        logic sp;
        tx_data = 8'h33; cs_sel = 2'd1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        sp = sck_m;
        for (int i = 0; i < 200 && edges < 5; i++) begin
            @(negedge clk);
            if (sck_m !== sp) edges++;
            sp = sck_m;
        end
        check_eq("rst_reach_edge5", edges, 5);
        #1 reset = 1'b1;
        #1;
        check_eq("rst_async", {cs_n_m, sck_m, busy_m, tx_ready_m, rx_valid_m},
                 {4'hF, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_ready_held", tx_ready_m, 0);
        @(negedge clk);
        check_eq("rst_ready_rise", tx_ready_m, 1);
        repeat (100) begin
            @(negedge clk);
            if (rx_valid_m === 1'b1) rxv++;
        end
        check_eq("rst_no_rx_valid", rxv, 0);
    endtask

    task automatic random_run(input int n);
        bit         pend = 0;
        bit         b2b, pre;
        logic [W-1:0] w, nw;
        logic [1:0] m, c;
        bit         l;
        nw = '0; m = MODE0; c = '0; l = 0;
        for (int i = 0; i < n; i++) begin
            w   = pend ? nw : W'($urandom);
            pre = pend;
            b2b = ($urandom_range(0, 3) == 0) && (i < n - 1);
            if (!pend) begin
                m = 2'($urandom);
                l = 1'($urandom);
                c = 2'($urandom);
            end
            nw = W'($urandom);
            transfer(w, W'($urandom), m, l, c, 1'($urandom), $urandom_range(0, 3) == 0, pre, b2b, nw);
            pend = b2b;
        end
    endtask

    initial begin
        reset = 1'b1; tx_valid = 1'b0; tx_data = '0; cs_sel = '0;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; miso = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_eq("reset_state",
                     {cs_n_m, sck_m, mosi_m, rx_data_m, rx_valid_m, busy_m, tx_ready_m},
                     {4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        end
        sel   = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_eq("ready_after_reset", tx_ready_m, 1);

        transfer(8'hA5, 8'h00, MODE0, 0, 2'd0, 1, 0, 0, 0, 8'h00);
        transfer(8'h3C, 8'h96, MODE3, 1, 2'd1, 0, 0, 0, 0, 8'h00);
        transfer(8'h4D, 8'hB2, MODE0, 0, 2'd2, 0, 0, 0, 0, 8'h00);
        transfer(8'h5A, 8'h0F, MODE2, 0, 2'd3, 0, 0, 0, 1, 8'hC3);
        transfer(8'hC3, 8'hE1, MODE2, 0, 2'd3, 0, 0, 1, 0, 8'h00);
        transfer(8'h69, 8'h1E, MODE1, 1, 2'd0, 0, 1, 0, 0, 8'h00);
        reset_mid();
        transfer(8'hFF, 8'h00, MODE0, 0, 2'd0, 1, 0, 0, 0, 8'h00);

        sel = 1'b1;
        @(negedge clk);
        transfer(8'h81, 8'h00, MODE1, 0, 2'd0, 1, 0, 0, 0, 8'h00);
        transfer(8'h55, 8'hAA, MODE0, 0, 2'd3, 0, 0, 0, 0, 8'h00);
        random_run(12);

        sel = 1'b0;
        @(negedge clk);
        random_run(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
